atsc_derandomizer: RTL and testbench
====================================

Name: atsc_derandomizer

Overview:
- Stage directly downstream of the RS decoder in the ATSC RX chain.
- Input: one RS-decoded segment per packet, 64 words of 32 bits (256-byte payload). Bytes 0..186 are data; bytes 187..255 are padding.
- Per data byte: XORs the ATSC 16-bit PRBS, prepends the MPEG sync byte 0x47, emits one 188-byte transport packet as 47 words, and drops the padding.
- The PRBS is preloaded at the first segment of each field; segments are counted internally and can be realigned by a field_sync pulse.

Parameters:
- SEGS_PER_FIELD, 312, data segments per field; the PRBS is preloaded when the segment count is 0.
- LFSR_INIT, 16'h018F, PRBS preload value.
- IN_PKT_WORDS, 64, nominal input packet length in words.

Ports:
- clk  in  1  block clock.
- reset  in  1  synchronous, active-high.
- i_tdata  in  32  input data; byte 0 of each word is [31:24].
- i_tlast  in  1  last word of input packet.
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- o_tdata  out  32  output data; byte 0 of each word is [31:24].
- o_tlast  out  1  asserted on output word 46 (or on an early-terminated word).
- o_tvalid  out  1  output valid.
- o_tready  in  1  downstream ready.
- field_sync  in  1  one-cycle pulse: the next packet that starts is segment 0 of a field.
- seg_cnt  out  9  index of the segment currently being processed or awaited.
- err_malformed  out  1  sticky flag for a bad packet length; cleared only by reset.

Behaviour:
- Reset state: o_tvalid=0, o_tlast=0, o_tdata=0, seg_cnt=0, err_malformed=0, word index=0, carry byte=0, lfsr=LFSR_INIT.
- PRBS output map (read from the current state): out[0]=s[15], out[1]=s[13], out[2]=s[12], out[3]=s[9], out[4]=s[5], out[5]=s[4], out[6]=s[3], out[7]=s[2].
- PRBS advance, one step per data byte: if s[0]=1 then s=((s^16'hA638)>>1)|16'h8000, else s=s>>1.
- Four steps are unrolled per word. Input word 46 uses only 3 steps (bytes 184..186), so exactly 187 steps occur per segment.
- The PRBS runs continuously across segments. It is reloaded with LFSR_INIT when input word 0 is accepted and seg_cnt==0.
- Byte mapping: d[n] = in byte n XOR prbs(n).
  - Output word 0 = {8'h47, d0, d1, d2}.
  - Output word j (1..46) = {d[4j-1], d[4j], d[4j+1], d[4j+2]}.
  - Input word j yields output word j. The carry register holds d[4j+3] for the next word.
- States:
  - PASS (word index 0..46): i_tready = ~o_tvalid | o_tready. Output register loads on an input handshake; latency is 1 cycle. At word 46 the block sets o_tlast and goes to DROP.
  - DROP (word index 47..63): i_tready=1 and nothing is emitted. Input tlast returns to PASS with index 0.
- Segment count: seg_cnt increments on the input tlast handshake and wraps from SEGS_PER_FIELD-1 to 0.
- field_sync:
  - Forces seg_cnt to 0. If it coincides with a tlast handshake, field_sync wins and seg_cnt=0.
  - If it arrives mid-packet, the current packet finishes with its existing PRBS and the next packet preloads.
- Early tlast (index < 46, in PASS): that word is emitted with o_tlast=1, err_malformed is set, seg_cnt increments, and the block returns to PASS at index 0.
- Missing tlast: if word 63 is accepted without tlast, err_malformed is set and the block stays in DROP until tlast.
- Back-pressure: o_tdata and o_tlast stay stable while o_tvalid=1 and o_tready=0. No word is lost or duplicated.
- Synchronous reset mid-packet returns everything to the reset state. The remainder of the interrupted packet is treated as a new packet.

Test Plan:
- All-zero input packet after reset (64 words, tlast on 63) -> output word 0 = 32'h47C06D3F. Exactly 47 output words with o_tlast on word 46. i_tready=1 throughout words 47..63. seg_cnt ends at 1.
- Random payload, 3 packets against a C model of the PRBS and mapping -> bit-exact output; PRBS continues across packets with no reload.
- 312 packets followed by a 313th -> seg_cnt wraps to 0 and the 313th packet's word 0 again equals {47, d0^C0, d1^6D, d2^3F}.
- field_sync pulsed during packet 5 -> packet 5 is unaffected; packet 6 preloads (word 0 of an all-zero packet = 32'h47C06D3F); seg_cnt=1 afterwards.
- Random o_tready toggling at 30% duty plus random i_tvalid gaps -> output sequence identical to the no-stall run; no data change while a word is stalled.
- Packet with tlast at word 20 -> word 20 emitted with o_tlast=1, err_malformed=1. Packet with 70 words -> 47 words out, err_malformed=1, next packet aligned.
- Reset asserted at input word 30 -> all outputs return to reset values the next cycle; the next full packet produces 32'h47C06D3F for all-zero input.

Source files
------------

// File: rtl/atsc_derandomizer.sv
// ATSC derandomizer: strips RS padding, removes the 16-bit field PRBS from each
// data byte and re-inserts the MPEG sync byte, turning 64-word segments into 47-word TS packets.
module atsc_derandomizer #(
    parameter int          SEGS_PER_FIELD = 312,
    parameter logic [15:0] LFSR_INIT      = 16'h018F,
    parameter int          IN_PKT_WORDS   = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [31:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
    input  logic        field_sync,
    output logic [8:0]  seg_cnt,
    output logic        err_malformed
);

    // Handshakes: a word moves on any rising edge where valid and ready are both
    // high; valid never waits on ready, and a held word keeps data/last stable.

    localparam logic [5:0] LAST_PASS_IDX = 6'd46;
    localparam logic [5:0] LAST_IN_IDX   = 6'(IN_PKT_WORDS - 1);
    localparam logic [8:0] SEG_LAST      = 9'(SEGS_PER_FIELD - 1);
    localparam logic [7:0] MPEG_SYNC     = 8'h47;

    typedef enum logic {
        ST_PASS = 1'b0,
        ST_DROP = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [5:0]  widx, widx_nxt;
    logic [15:0] lfsr, lfsr_nxt;
    logic [7:0]  carry, carry_nxt;
    logic [31:0] odata_nxt;
    logic        olast_nxt, ovalid_nxt;
    logic [8:0]  seg_nxt;
    logic        err_nxt;
    logic        sync_pend, sync_pend_nxt;

    logic [15:0] s0, s1, s2, s3, s4;
    logic [7:0]  d0, d1, d2, d3;
    logic [31:0] pass_word;
    logic        in_hs, pkt_end, at_last_pass, mid_pkt;

    function automatic logic [7:0] prbs_byte(input logic [15:0] s);
        return {s[2], s[3], s[4], s[5], s[9], s[12], s[13], s[15]};
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        if (s[0])
            return ((s ^ 16'hA638) >> 1) | 16'h8000;
        return s >> 1;
    endfunction

    assign i_tready     = (state == ST_DROP) | ~o_tvalid | o_tready;
    assign in_hs        = i_tvalid & i_tready;
    assign pkt_end      = in_hs & i_tlast;
    assign at_last_pass = (widx == LAST_PASS_IDX);
    assign mid_pkt      = (state == ST_DROP) | (widx != 6'd0);

    // Four PRBS steps per word; the field preload happens on word 0 of segment 0.
    always_comb begin
        s0 = lfsr;
        if (widx == 6'd0 && seg_cnt == 9'd0)
            s0 = LFSR_INIT;
        s1 = lfsr_step(s0);
        s2 = lfsr_step(s1);
        s3 = lfsr_step(s2);
        s4 = lfsr_step(s3);
        d0 = i_tdata[31:24] ^ prbs_byte(s0);
        d1 = i_tdata[23:16] ^ prbs_byte(s1);
        d2 = i_tdata[15:8]  ^ prbs_byte(s2);
        d3 = i_tdata[7:0]   ^ prbs_byte(s3);
        if (widx == 6'd0)
            pass_word = {MPEG_SYNC, d0, d1, d2};
        else
            pass_word = {carry, d0, d1, d2};
    end

    always_comb begin
        state_nxt     = state;
        widx_nxt      = widx;
        lfsr_nxt      = lfsr;
        carry_nxt     = carry;
        odata_nxt     = o_tdata;
        olast_nxt     = o_tlast;
        ovalid_nxt    = o_tvalid & ~o_tready;
        seg_nxt       = seg_cnt;
        err_nxt       = err_malformed;
        sync_pend_nxt = sync_pend;

        case (state)
            ST_PASS: begin
                if (in_hs) begin
                    odata_nxt  = pass_word;
                    olast_nxt  = i_tlast | at_last_pass;
                    ovalid_nxt = 1'b1;
                    carry_nxt  = d3;
                    // Byte 187 (last byte of word 46) is padding and takes no PRBS step.
                    lfsr_nxt   = at_last_pass ? s3 : s4;
                    if (i_tlast) begin
                        widx_nxt = 6'd0;
                        if (widx < LAST_PASS_IDX)
                            err_nxt = 1'b1;
                    end else if (at_last_pass) begin
                        state_nxt = ST_DROP;
                        widx_nxt  = widx + 6'd1;
                    end else begin
                        widx_nxt = widx + 6'd1;
                    end
                end
            end
            ST_DROP: begin
                if (in_hs) begin
                    if (i_tlast) begin
                        state_nxt = ST_PASS;
                        widx_nxt  = 6'd0;
                    end else if (widx == LAST_IN_IDX) begin
                        // Overlong segment: park here until its tlast shows up.
                        err_nxt = 1'b1;
                    end else begin
                        widx_nxt = widx + 6'd1;
                    end
                end
            end
            default: state_nxt = ST_PASS;
        endcase

        // A mid-packet field_sync is remembered so the segment it lands in still
        // finishes with its running PRBS and the following one preloads.
        if (pkt_end) begin
            if (field_sync | sync_pend)
                seg_nxt = 9'd0;
            else if (seg_cnt == SEG_LAST)
                seg_nxt = 9'd0;
            else
                seg_nxt = seg_cnt + 9'd1;
            sync_pend_nxt = 1'b0;
        end else if (field_sync) begin
            seg_nxt       = 9'd0;
            sync_pend_nxt = mid_pkt | in_hs;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_PASS;
            widx          <= 6'd0;
            lfsr          <= LFSR_INIT;
            carry         <= 8'd0;
            o_tdata       <= 32'd0;
            o_tlast       <= 1'b0;
            o_tvalid      <= 1'b0;
            seg_cnt       <= 9'd0;
            err_malformed <= 1'b0;
            sync_pend     <= 1'b0;
        end else begin
            state         <= state_nxt;
            widx          <= widx_nxt;
            lfsr          <= lfsr_nxt;
            carry         <= carry_nxt;
            o_tdata       <= odata_nxt;
            o_tlast       <= olast_nxt;
            o_tvalid      <= ovalid_nxt;
            seg_cnt       <= seg_nxt;
            err_malformed <= err_nxt;
            sync_pend     <= sync_pend_nxt;
        end
    end

endmodule

// File: tb/tb_atsc_derandomizer.sv
// Bench for atsc_derandomizer: fill-pattern table, random payloads with stalls,
// field wrap, field_sync, malformed lengths and mid-packet reset.
module tb_atsc_derandomizer;

    localparam int          SEGS = 312;
    localparam logic [15:0] INIT = 16'h018F;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_tdata;
    logic        i_tlast, i_tvalid, i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast, o_tvalid, o_tready;
    logic        field_sync;
    logic [8:0]  seg_cnt;
    logic        err_malformed;

    atsc_derandomizer dut (
        .clk(clk), .reset(reset),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
        .field_sync(field_sync), .seg_cnt(seg_cnt), .err_malformed(err_malformed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  fill;
        logic [31:0] exp_w0;
    } vec_t;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [32:0] exp_q[$];
    logic [7:0]  pb[0:279];
    logic [7:0]  pay[0:2][0:255];
    logic [15:0] m_lfsr;
    int          m_seg;
    logic        rnd_mode, hold_low, mon_en;
    int          out_cnt;
    logic [31:0] first_word;
    logic        stalled;
    logic [32:0] stall_val;
    logic        accepted, rdy_seen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] prbs_of(input logic [15:0] s);
        logic [7:0] r;
        r[0] = s[15]; r[1] = s[13]; r[2] = s[12]; r[3] = s[9];
        r[4] = s[5];  r[5] = s[4];  r[6] = s[3];  r[7] = s[2];
        return r;
    endfunction

    function automatic logic [15:0] adv(input logic [15:0] s);
        if (s[0]) return ((s ^ 16'hA638) >> 1) | 16'h8000;
        return s >> 1;
    endfunction

    function automatic logic [31:0] pw(input int w);
        return {pb[4*w], pb[4*w+1], pb[4*w+2], pb[4*w+3]};
    endfunction

    // Byte-serial reference: derandomize the data bytes, then repack into words.
    task automatic model_pkt(input int tlast_idx);
        logic [7:0] d[0:187];
        int k, nd;
        k  = (tlast_idx < 46) ? tlast_idx : 46;
        nd = (k == 46) ? 187 : 4*k + 4;
        if (m_seg == 0) m_lfsr = INIT;
        for (int n = 0; n < nd; n++) begin
            d[n]   = pb[n] ^ prbs_of(m_lfsr);
            m_lfsr = adv(m_lfsr);
        end
        exp_q.push_back({(k == 0), 8'h47, d[0], d[1], d[2]});
        for (int j = 1; j <= k; j++)
            exp_q.push_back({(j == k), d[4*j-1], d[4*j], d[4*j+1], d[4*j+2]});
        m_seg = (m_seg == SEGS-1) ? 0 : m_seg + 1;
    endtask

    // One clock: inputs already set at the negedge, sample #1 later, return at next negedge.
    task automatic cycle();
        logic [32:0] e;
        o_tready = hold_low ? 1'b0 : (rnd_mode ? ($urandom_range(0, 99) < 30) : 1'b1);
        #1;
        if (mon_en) begin
            if (stalled)
                check("stall_hold", 64'({o_tvalid, o_tlast, o_tdata}), 64'({1'b1, stall_val}));
            if (o_tvalid && o_tready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL out_extra: got %h expected no word", {o_tlast, o_tdata});
                end else begin
                    e = exp_q.pop_front();
                    check("out_word", 64'({o_tlast, o_tdata}), 64'(e));
                end
                if (out_cnt == 0) first_word = o_tdata;
                out_cnt++;
            end
            stalled   = o_tvalid && !o_tready;
            stall_val = {o_tlast, o_tdata};
        end
        rdy_seen = i_tready;
        accepted = i_tvalid && i_tready;
        @(negedge clk);
        field_sync = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last, input logic drop_chk);
        int guard;
        guard = 0;
        if (rnd_mode)
            while ($urandom_range(0, 3) == 0) begin
                i_tvalid = 1'b0;
                cycle();
            end
        i_tvalid = 1'b1; i_tdata = d; i_tlast = last; hold_low = drop_chk;
        cycle();
        if (drop_chk) check("drop_ready", 64'(rdy_seen), 64'(1));
        while (!accepted && guard < 1000) begin
            cycle();
            guard++;
        end
        if (!accepted) begin
            n_chk++;
            $display("FAIL in_timeout: got no accept expected accept");
        end
        i_tvalid = 1'b0; i_tlast = 1'b0; hold_low = 1'b0;
    endtask

    task automatic send_pkt(input int nwords, input int sync_at, input logic drop_chk);
        for (int w = 0; w < nwords; w++) begin
            if (w == sync_at) field_sync = 1'b1;
            send_word(pw(w), (w == nwords-1), drop_chk && (w >= 47));
            if (w == sync_at && w != nwords-1) check("sync_seg", 64'(seg_cnt), 64'(0));
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        i_tvalid = 1'b0;
        while ((exp_q.size() != 0 || o_tvalid) && g < 500) begin
            cycle();
            g++;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: got %0d words missing expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        mon_en = 1'b0; hold_low = 1'b1; reset = 1'b1; i_tvalid = 1'b0;
        cycle();
        cycle();
        reset = 1'b0; hold_low = 1'b0; mon_en = 1'b1; stalled = 1'b0;
        exp_q.delete();
        m_lfsr = INIT; m_seg = 0;
    endtask

    task automatic load_pay(input int p);
        for (int i = 0; i < 256; i++) pb[i] = pay[p][i];
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[4];
        vt[0] = '{fill: 8'h00, exp_w0: 32'h47C06D3F};
        vt[1] = '{fill: 8'hFF, exp_w0: 32'h473F92C0};
        vt[2] = '{fill: 8'hA5, exp_w0: 32'h4765C89A};
        vt[3] = '{fill: 8'h5A, exp_w0: 32'h479A3765};

        reset = 1'b1; i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;
        field_sync = 1'b0; rnd_mode = 1'b0; hold_low = 1'b0; mon_en = 1'b0;
        stalled = 1'b0; out_cnt = 0; first_word = '0; accepted = 1'b0; rdy_seen = 1'b0;
        m_lfsr = INIT; m_seg = 0;
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 256; i++) pay[p][i] = 8'($urandom);

        @(negedge clk);
        do_reset();
        check("rst_tvalid", 64'(o_tvalid), 64'(0));
        check("rst_tlast", 64'(o_tlast), 64'(0));
        check("rst_tdata", 64'(o_tdata), 64'(0));
        check("rst_seg", 64'(seg_cnt), 64'(0));
        check("rst_err", 64'(err_malformed), 64'(0));
        check("rst_ready", 64'(i_tready), 64'(1));

        // Constant-fill packets after reset, with output held off during the drop phase.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            for (int i = 0; i < 280; i++) pb[i] = vt[v].fill;
            out_cnt = 0;
            model_pkt(63);
            send_pkt(64, -1, 1'b1);
            drain();
            check("tbl_w0", 64'(first_word), 64'(vt[v].exp_w0));
            check("tbl_nout", 64'(out_cnt), 64'(47));
            check("tbl_seg", 64'(seg_cnt), 64'(1));
            check("tbl_err", 64'(err_malformed), 64'(0));
        end

        // Random payloads, PRBS runs on across packets; then same payloads under stalls and gaps.
        for (int run = 0; run < 2; run++) begin
            rnd_mode = (run == 1);
            do_reset();
            for (int p = 0; p < 3; p++) begin
                load_pay(p);
                model_pkt(63);
                send_pkt(64, -1, 1'b0);
            end
            drain();
            check("rand_seg", 64'(seg_cnt), 64'(3));
        end
        rnd_mode = 1'b0;

        // Field wrap: 312 segments, then segment 0 preloads again.
        do_reset();
        for (int i = 0; i < 280; i++) pb[i] = 8'h00;
        for (int p = 0; p < SEGS; p++) begin
            model_pkt(63);
            send_pkt(64, -1, 1'b0);
            drain();
        end
        check("wrap_seg", 64'(seg_cnt), 64'(0));
        load_pay(0);
        out_cnt = 0;
        model_pkt(63);
        send_pkt(64, -1, 1'b0);
        drain();
        check("wrap_w0", 64'(first_word),
              64'({8'h47, pb[0] ^ 8'hC0, pb[1] ^ 8'h6D, pb[2] ^ 8'h3F}));

        // field_sync in packet 5 (mid-packet), then coinciding with a tlast.
        do_reset();
        for (int i = 0; i < 280; i++) pb[i] = 8'h00;
        for (int p = 0; p < 4; p++) begin
            model_pkt(63);
            send_pkt(64, -1, 1'b0);
        end
        drain();
        model_pkt(63);
        send_pkt(64, 10, 1'b0);
        drain();
        m_seg = 0;
        check("fs_seg_p5", 64'(seg_cnt), 64'(0));
        out_cnt = 0;
        model_pkt(63);
        send_pkt(64, -1, 1'b0);
        drain();
        check("fs_w0_p6", 64'(first_word), 64'(32'h47C06D3F));
        check("fs_seg_p6", 64'(seg_cnt), 64'(1));
        model_pkt(63);
        send_pkt(64, 63, 1'b0);
        drain();
        m_seg = 0;
        check("fs_seg_tl", 64'(seg_cnt), 64'(0));
        out_cnt = 0;
        model_pkt(63);
        send_pkt(64, -1, 1'b0);
        drain();
        check("fs_w0_p8", 64'(first_word), 64'(32'h47C06D3F));

        // Early tlast at word 20, then an overlong 70-word packet, then a normal one.
        do_reset();
        for (int i = 0; i < 280; i++) pb[i] = 8'($urandom);
        out_cnt = 0;
        model_pkt(20);
        send_pkt(21, -1, 1'b0);
        drain();
        check("early_nout", 64'(out_cnt), 64'(21));
        check("early_err", 64'(err_malformed), 64'(1));
        check("early_seg", 64'(seg_cnt), 64'(1));
        out_cnt = 0;
        model_pkt(69);
        send_pkt(70, -1, 1'b0);
        drain();
        check("long_nout", 64'(out_cnt), 64'(47));
        check("long_err", 64'(err_malformed), 64'(1));
        load_pay(1);
        model_pkt(63);
        send_pkt(64, -1, 1'b0);
        drain();
        check("after_seg", 64'(seg_cnt), 64'(3));

        // Reset at input word 30 while an output word is held.
        for (int i = 0; i < 280; i++) pb[i] = 8'h00;
        model_pkt(63);
        for (int w = 0; w < 30; w++) send_word(pw(w), 1'b0, 1'b0);
        hold_low = 1'b1; i_tvalid = 1'b1; i_tdata = pw(30); reset = 1'b1;
        cycle();
        mon_en = 1'b0;
        check("mrst_tvalid", 64'(o_tvalid), 64'(0));
        check("mrst_tlast", 64'(o_tlast), 64'(0));
        check("mrst_tdata", 64'(o_tdata), 64'(0));
        check("mrst_seg", 64'(seg_cnt), 64'(0));
        check("mrst_err", 64'(err_malformed), 64'(0));
        reset = 1'b0; hold_low = 1'b0; i_tvalid = 1'b0; mon_en = 1'b1; stalled = 1'b0;
        exp_q.delete();
        m_lfsr = INIT; m_seg = 0;
        out_cnt = 0;
        model_pkt(63);
        send_pkt(64, -1, 1'b0);
        drain();
        check("mrst_w0", 64'(first_word), 64'(32'h47C06D3F));
        check("mrst_nout", 64'(out_cnt), 64'(47));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
